// File: rtl/vx_stream_dispatch_pkg.sv
// Shared definitions for the stream dispatcher: lane-selection policy codes
// and the index-width helper used for lane numbers.
package vx_stream_dispatch_pkg;

  localparam int DISPATCH_POLICY_FIRST = 0;
  localparam int DISPATCH_POLICY_RR    = 1;

  // Bits needed to hold an index in 0..n-1, never less than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_dispatch_lane_buf.sv
// Two-entry registered elastic buffer for one dispatch lane. The head entry
// drives the output directly, so the consumer sees registered data/valid.
module vx_dispatch_lane_buf #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [DATAW-1:0] data
);

  logic [1:0]       count_r;
  logic [DATAW-1:0] head_r;
  logic [DATAW-1:0] tail_r;
  logic             push_s;
  logic             pop_s;

  // Guard the handshakes so a stray push into a full buffer or a pop from an
  // empty one can never corrupt the occupancy count.
  always_comb begin
    push_s = push & (count_r != 2'd2);
    pop_s  = pop  & (count_r != 2'd0);
  end

  // Occupancy and storage update; push+pop only happens at count 1, where the
  // incoming item replaces the departing head.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 2'd0;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= push_data;
          end else begin
            tail_r <= push_data;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          head_r <= push_data;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign full  = (count_r == 2'd2);
  assign valid = (count_r != 2'd0);
  assign data  = head_r;

endmodule

// File: rtl/vx_stream_dispatch_chk.sv
// Simulation-only checks on the dispatcher's enqueue side.
module vx_stream_dispatch_chk
  import vx_stream_dispatch_pkg::*;
#(
  parameter int N = 4
) (
  input logic                   clk,
  input logic                   reset,
  input logic [N-1:0]           push,
  input logic [N-1:0]           full,
  input logic [log2up(N)-1:0]   sel
);

  // Each cycle: one lane at most is written, the lane index is in range and
  // no full lane receives an item.
  always @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(push));
      assert (int'(sel) < N);
      assert ((push & full) == '0);
    end
  end

endmodule

// File: rtl/vx_stream_dispatch.sv
// One-to-N stream dispatcher: each accepted item is steered to one lane with
// buffer space, picked by fixed priority or round-robin. ready_in depends only
// on lane occupancy, so there is no combinational path from ready_out.
module vx_stream_dispatch
  import vx_stream_dispatch_pkg::*;
#(
  parameter int N       = 4,
  parameter int DATAW   = 32,
  parameter int POLICY  = 0,
  parameter int REVERSE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        valid_in,
  input  logic [DATAW-1:0]            data_in,
  output logic                        ready_in,
  output logic [log2up(N)-1:0]        sel_in,
  output logic [N-1:0]                valid_out,
  output logic [N-1:0][DATAW-1:0]     data_out,
  input  logic [N-1:0]                ready_out
);

  localparam int LOGN = log2up(N);

  logic [N-1:0]    full_s;
  logic [N-1:0]    eligible_s;
  logic [N-1:0]    push_s;
  logic [N-1:0]    pop_s;
  logic [LOGN-1:0] sel_s;
  logic [LOGN-1:0] rr_next_s;
  logic [LOGN-1:0] rr_ptr_r;
  logic            fire_s;
  logic            found_s;
  int              cand_s;

  assign eligible_s = ~full_s;
  assign ready_in   = |eligible_s;
  assign fire_s     = valid_in & ready_in;
  assign sel_in     = sel_s;

  // Find-first lane selection; sel stays 0 when no lane has space.
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    if (POLICY == DISPATCH_POLICY_RR) begin
      for (int i = 0; i < N; i++) begin
        cand_s = ((int'(rr_ptr_r) + i) >= N) ? (int'(rr_ptr_r) + i - N)
                                             : (int'(rr_ptr_r) + i);
        if (!found_s && eligible_s[cand_s]) begin
          sel_s   = LOGN'(cand_s);
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else if (REVERSE != 0) begin
      // Ascending scan, last hit wins: highest free index.
      for (int i = 0; i < N; i++) begin
        if (eligible_s[i]) begin
          sel_s = LOGN'(i);
        end else begin
          sel_s = sel_s;
        end
      end
    end else begin
      // Descending scan, last hit wins: lowest free index.
      for (int i = N - 1; i >= 0; i--) begin
        if (eligible_s[i]) begin
          sel_s = LOGN'(i);
        end else begin
          sel_s = sel_s;
        end
      end
    end
  end

  // Lane after the granted one, wrapped explicitly for non-power-of-2 N.
  always_comb begin
    if ((int'(sel_s) + 1) >= N) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = LOGN'(int'(sel_s) + 1);
    end
  end

  // Round-robin pointer advances only on an accepted item.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (fire_s && (POLICY == DISPATCH_POLICY_RR)) begin
      rr_ptr_r <= rr_next_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign push_s[k] = fire_s & (sel_s == LOGN'(k));
    assign pop_s[k]  = valid_out[k] & ready_out[k];

    vx_dispatch_lane_buf #(
      .DATAW (DATAW)
    ) u_buf (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s[k]),
      .push_data (data_in),
      .pop       (pop_s[k]),
      .full      (full_s[k]),
      .valid     (valid_out[k]),
      .data      (data_out[k])
    );
  end

  vx_stream_dispatch_chk #(
    .N (N)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .full  (full_s),
    .sel   (sel_s)
  );

endmodule
